// File: rtl/arcade_input_mapper.sv
`default_nettype none
// ============================================================================
// Module   : arcade_input_mapper
// Purpose  : Player-input front end for arcade cores. Decodes PS/2 key
//            events and per-player joystick words into registered,
//            active-high direction / fire / start / skip / coin controls,
//            with screen-rotation remapping and a coin-then-start sequencer.
// Options  : INPUT_AUTOFIRE_EN - when defined, adds per-player autofire.
// Revision : 1.0 - initial release
// ============================================================================
module arcade_input_mapper #(
  parameter int PLAYERS        = 2,
  parameter int TICK_DIV       = 24000,
  parameter int COIN_TICKS     = 100,
  parameter int GAP_TICKS      = 100,
  parameter int START_TICKS    = 100,
  parameter int AUTOFIRE_TICKS = 4
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [10:0]            ps2_key,
  input  logic [16*PLAYERS-1:0]  joy,
  input  logic [1:0]             rotate,
  input  logic [PLAYERS-1:0]     autofire_en,
  output logic [4*PLAYERS-1:0]   out_dir,
  output logic [PLAYERS-1:0]     out_fire,
  output logic [PLAYERS-1:0]     out_start,
  output logic                   out_skip,
  output logic                   out_coin,
  output logic                   busy
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_MAX_TICKS = (COIN_TICKS > GAP_TICKS) ?
                               ((COIN_TICKS > START_TICKS) ? COIN_TICKS : START_TICKS) :
                               ((GAP_TICKS > START_TICKS) ? GAP_TICKS : START_TICKS);
  localparam int c_PRE_W = $clog2(TICK_DIV + 1);
  localparam int c_TCK_W = $clog2(c_MAX_TICKS + 1);
  localparam int c_IDX_W = (PLAYERS > 1) ? $clog2(PLAYERS) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_LAST   = c_PRE_W'(TICK_DIV - 1);
  localparam logic [c_TCK_W-1:0] c_COIN_LAST  = c_TCK_W'(COIN_TICKS - 1);
  localparam logic [c_TCK_W-1:0] c_GAP_LAST   = c_TCK_W'(GAP_TICKS - 1);
  localparam logic [c_TCK_W-1:0] c_START_LAST = c_TCK_W'(START_TICKS - 1);

`ifdef INPUT_AUTOFIRE_EN
  localparam int                 c_AF_W    = $clog2(AUTOFIRE_TICKS + 1);
  localparam logic [c_AF_W-1:0]  c_AF_LAST = c_AF_W'(AUTOFIRE_TICKS - 1);
`endif

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_COIN  = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;
  localparam logic [1:0] c_ST_START = 2'd3;

  // --------------------------------------------------------------------------
  // Keyboard decode
  // --------------------------------------------------------------------------
  logic       r_key_tog;
  logic       r_kb_up;
  logic       r_kb_down;
  logic       r_kb_left;
  logic       r_kb_right;
  logic       r_kb_fire_a;
  logic       r_kb_fire_b;
  logic       r_kb_skip;
  logic       w_key_event;
  logic       w_key_pressed;
  logic [8:0] w_key_code;

  assign w_key_event   = (ps2_key[10] != r_key_tog);
  assign w_key_pressed = ps2_key[9];
  assign w_key_code    = ps2_key[8:0];

  // Track the toggle bit and latch held state of the shared (player 0) keys.
  // Direction keys match on the low byte only so the E0 prefix is ignored.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key_tog   <= ps2_key[10];
      r_kb_up     <= 1'b0;
      r_kb_down   <= 1'b0;
      r_kb_left   <= 1'b0;
      r_kb_right  <= 1'b0;
      r_kb_fire_a <= 1'b0;
      r_kb_fire_b <= 1'b0;
      r_kb_skip   <= 1'b0;
    end else begin
      r_key_tog <= ps2_key[10];
      if (w_key_event) begin
        if (w_key_code[7:0] == 8'h75) r_kb_up     <= w_key_pressed;
        if (w_key_code[7:0] == 8'h72) r_kb_down   <= w_key_pressed;
        if (w_key_code[7:0] == 8'h6B) r_kb_left   <= w_key_pressed;
        if (w_key_code[7:0] == 8'h74) r_kb_right  <= w_key_pressed;
        if (w_key_code == 9'h029)     r_kb_fire_a <= w_key_pressed;
        if (w_key_code == 9'h014)     r_kb_fire_b <= w_key_pressed;
        if (w_key_code == 9'h003)     r_kb_skip   <= w_key_pressed;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-player merge, rotation, fire
  // --------------------------------------------------------------------------
  logic [PLAYERS-1:0] w_start_req;
  logic [PLAYERS-1:0] w_pad_skip;
  logic [PLAYERS-1:0] w_pad_unused;

  genvar p;
  generate
    for (p = 0; p < PLAYERS; p = p + 1) begin : g_player
      localparam logic [8:0] c_START_CODE = (p == 0) ? 9'h005 :
                                            (p == 1) ? 9'h006 :
                                            (p == 2) ? 9'h004 : 9'h00C;
      logic [15:0] w_joy_word;
      logic        r_kb_start;
      logic        w_up;
      logic        w_down;
      logic        w_left;
      logic        w_right;
      logic        w_fire;
      logic [3:0]  w_rot;
      logic [3:0]  r_dir;
      logic        r_fire_o;

      assign w_joy_word = joy[16*p +: 16];

      // Held state of this player's keyboard start key.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_kb_start <= 1'b0;
        end else if (w_key_event && (w_key_code == c_START_CODE)) begin
          r_kb_start <= w_key_pressed;
        end
      end

      if (p == 0) begin : g_kb_merge
        assign w_up    = w_joy_word[3] | r_kb_up;
        assign w_down  = w_joy_word[2] | r_kb_down;
        assign w_left  = w_joy_word[1] | r_kb_left;
        assign w_right = w_joy_word[0] | r_kb_right;
        assign w_fire  = w_joy_word[4] | r_kb_fire_a | r_kb_fire_b;
      end else begin : g_pad_only
        assign w_up    = w_joy_word[3];
        assign w_down  = w_joy_word[2];
        assign w_left  = w_joy_word[1];
        assign w_right = w_joy_word[0];
        assign w_fire  = w_joy_word[4];
      end

      assign w_start_req[p]  = w_joy_word[5] | r_kb_start;
      assign w_pad_skip[p]   = w_joy_word[7];
      assign w_pad_unused[p] = ^{w_joy_word[15:8], w_joy_word[6]};

      // Remap logical directions to screen orientation; result is {u,d,l,r}.
      always_comb begin
        w_rot = {w_up, w_down, w_left, w_right};
        case (rotate)
          2'd1:    w_rot = {w_left,  w_right, w_down, w_up};
          2'd2:    w_rot = {w_down,  w_up,    w_right, w_left};
          2'd3:    w_rot = {w_right, w_left,  w_up,   w_down};
          default: w_rot = {w_up,    w_down,  w_left, w_right};
        endcase
      end

      // Register the rotated direction nibble.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_dir <= 4'b0000;
        end else begin
          r_dir <= w_rot;
        end
      end

`ifdef INPUT_AUTOFIRE_EN
      logic               r_fire_prev;
      logic               r_phase;
      logic [c_PRE_W-1:0] r_af_pre;
      logic [c_AF_W-1:0]  r_af_tck;
      logic               w_fire_rise;
      logic               w_af_last;
      logic               w_phase_next;

      assign w_fire_rise  = w_fire & ~r_fire_prev;
      assign w_af_last    = (r_af_pre == c_PRE_LAST) && (r_af_tck == c_AF_LAST);
      assign w_phase_next = w_fire_rise ? 1'b1 : (w_af_last ? ~r_phase : r_phase);

      // Autofire phase: restarts high on each fire press, flips every half-period.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_fire_prev <= 1'b0;
          r_phase     <= 1'b0;
          r_af_pre    <= '0;
          r_af_tck    <= '0;
          r_fire_o    <= 1'b0;
        end else begin
          r_fire_prev <= w_fire;
          r_phase     <= w_phase_next;
          if (w_fire_rise) begin
            r_af_pre <= '0;
            r_af_tck <= '0;
          end else if (w_fire) begin
            if (r_af_pre == c_PRE_LAST) begin
              r_af_pre <= '0;
              r_af_tck <= (r_af_tck == c_AF_LAST) ? '0 : r_af_tck + c_AF_W'(1);
            end else begin
              r_af_pre <= r_af_pre + c_PRE_W'(1);
            end
          end
          r_fire_o <= w_fire & (autofire_en[p] ? w_phase_next : 1'b1);
        end
      end
`else
      // Plain fire: one-cycle registered copy of the logical fire.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          r_fire_o <= 1'b0;
        end else begin
          r_fire_o <= w_fire;
        end
      end
`endif

      assign out_dir[4*p +: 4] = r_dir;
      assign out_fire[p]       = r_fire_o;
    end
  endgenerate

  // Bits of the joystick words (and options) that this block does not use.
  logic w_unused;
`ifdef INPUT_AUTOFIRE_EN
  assign w_unused = ^w_pad_unused;
`else
  assign w_unused = ^{w_pad_unused, autofire_en, AUTOFIRE_TICKS};
`endif

  // --------------------------------------------------------------------------
  // Skip
  // --------------------------------------------------------------------------
  logic r_skip;

  // Skip comes from F5 or any player's skip button.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_skip <= 1'b0;
    end else begin
      r_skip <= r_kb_skip | (|w_pad_skip);
    end
  end

  assign out_skip = r_skip;

  // --------------------------------------------------------------------------
  // Coin-then-start sequencer
  // --------------------------------------------------------------------------
  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_PRE_W-1:0] r_pre;
  logic [c_PRE_W-1:0] w_pre_next;
  logic [c_TCK_W-1:0] r_tck;
  logic [c_TCK_W-1:0] w_tck_next;
  logic [c_TCK_W-1:0] w_tck_last;
  logic [c_IDX_W-1:0] r_player;
  logic [c_IDX_W-1:0] w_player_next;
  logic [PLAYERS-1:0] r_req_prev;
  logic [PLAYERS-1:0] w_req_rise;
  logic               r_coin;
  logic               r_busy;
  logic [PLAYERS-1:0] r_start;

  assign w_req_rise = w_start_req & ~r_req_prev;

  // Final tick index of the current timed state.
  always_comb begin
    w_tck_last = c_COIN_LAST;
    case (r_state)
      c_ST_GAP:   w_tck_last = c_GAP_LAST;
      c_ST_START: w_tck_last = c_START_LAST;
      default:    w_tck_last = c_COIN_LAST;
    endcase
  end

  // Next-state logic: idle waits for a fresh start edge, timed states count
  // TICK_DIV-cycle ticks and advance on the last one.
  always_comb begin
    w_state_next  = r_state;
    w_pre_next    = r_pre;
    w_tck_next    = r_tck;
    w_player_next = r_player;
    case (r_state)
      c_ST_IDLE: begin
        if (|w_req_rise) begin
          w_state_next = c_ST_COIN;
          w_pre_next   = '0;
          w_tck_next   = '0;
          for (int i = PLAYERS - 1; i >= 0; i--) begin
            if (w_req_rise[i]) w_player_next = c_IDX_W'(i);
          end
        end
      end
      default: begin
        if (r_pre == c_PRE_LAST) begin
          w_pre_next = '0;
          if (r_tck == w_tck_last) begin
            w_tck_next   = '0;
            w_state_next = (r_state == c_ST_COIN) ? c_ST_GAP :
                           (r_state == c_ST_GAP)  ? c_ST_START : c_ST_IDLE;
          end else begin
            w_tck_next = r_tck + c_TCK_W'(1);
          end
        end else begin
          w_pre_next = r_pre + c_PRE_W'(1);
        end
      end
    endcase
  end

  // State, counters and outputs registered from the next-state decode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= c_ST_IDLE;
      r_pre      <= '0;
      r_tck      <= '0;
      r_player   <= '0;
      r_req_prev <= '0;
      r_coin     <= 1'b0;
      r_busy     <= 1'b0;
      r_start    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pre      <= w_pre_next;
      r_tck      <= w_tck_next;
      r_player   <= w_player_next;
      r_req_prev <= w_start_req;
      r_coin     <= (w_state_next == c_ST_COIN);
      r_busy     <= (w_state_next != c_ST_IDLE);
      for (int i = 0; i < PLAYERS; i++) begin
        r_start[i] <= (w_state_next == c_ST_START) && (w_player_next == c_IDX_W'(i));
      end
    end
  end

  assign out_coin  = r_coin;
  assign busy      = r_busy;
  assign out_start = r_start;

endmodule
`default_nettype wire

// File: doc/arcade_input_mapper.md
# arcade_input_mapper

Parametrised player-input front end for arcade cores: decodes PS/2 key events and per-player MiSTer joystick words into registered, active-high direction, fire, start, skip and coin controls. It sits between `hps_io` and the game core's active-low input ports. It adds four-way screen-rotation remapping, N-player support, a timed coin-then-start sequencer and optional autofire.

## Interface
Parameters:
- `PLAYERS`, 2: player count, 1..4.
- `TICK_DIV`, 24000: `CLK` cycles per timer tick.
- `COIN_TICKS`, 100: coin pulse length, in ticks.
- `GAP_TICKS`, 100: delay from coin to start, in ticks.
- `START_TICKS`, 100: start pulse length, in ticks.
- `AUTOFIRE_TICKS`, 4: autofire half-period, in ticks.

Ports:
- `CLK` in 1: system clock; one clock domain.
- `RESET` in 1: synchronous, active-high.
- `ps2_key` in 11: [10] toggle, [9] pressed, [8:0] scancode.
- `joy` in 16*PLAYERS: player k in [16k+15:16k]; bit 0 right, 1 left, 2 down, 3 up, 4 fire, 5 start, 7 skip.
- `rotate` in 2: 0 none, 1 = 90°, 2 = 180°, 3 = 270°.
- `autofire_en` in PLAYERS: per-player autofire enable.
- `out_dir` out 4*PLAYERS: player k in [4k+3:4k] = {up,down,left,right}.
- `out_fire` out PLAYERS.
- `out_start` out PLAYERS.
- `out_skip` out 1.
- `out_coin` out 1.
- `busy` out 1: sequencer not idle.

## Operation
- **Keyboard decode**
  - An event is a change of `ps2_key[10]` against its stored copy. Each event writes `pressed` into the matching held bit.
  - Key map: X75 up, X72 down, X6B left, X74 right; extended prefix is ignored. 029 and 014 fire. 005/006/004/00C start for players 0/1/2/3. 003 skip.
  - Start keys for players that do not exist are ignored. Direction and fire keys drive player 0 only.
- **Merge**
  - Player 0 logical input = keyboard held bits OR `joy` word 0.
  - Players k>0 use `joy` word k alone.
  - Skip = F5 OR any player's bit 7.
- **Rotation** (same mapping for every player, listed as output←input):
  - 0: identity.
  - 1: up←left, down←right, left←down, right←up.
  - 2: up←down, down←up, left←right, right←left.
  - 3: up←right, down←left, left←up, right←down.
- **Sequencer FSM**, states IDLE, COIN, GAP, START:
  - Start request k = logical start bit k.
  - In IDLE, a rising edge on any request latches the lowest such k and enters COIN.
  - COIN drives `out_coin`=1, then moves to GAP. GAP drives nothing, then moves to START. START drives `out_start[k]`=1, then returns to IDLE.
  - Each state lasts exactly its tick count × `TICK_DIV` cycles. The tick prescaler restarts on every state entry.
  - Requests outside IDLE are discarded; their edges are not queued. A request held through to IDLE does not retrigger; only a new rising edge does.
  - `busy` = state≠IDLE.
- **Fire**: `out_fire[k]` = logical fire, unless autofire applies (see Configuration).

## Timing
- Reset value of every output is 0.
- On reset:
  - FSM goes to IDLE.
  - Held keys, prescalers, edge registers and autofire counters are cleared.
  - The stored toggle copy loads `ps2_key[10]`, so reset generates no event.
- All outputs are registered.
- Latency from a `joy` or `rotate` change to outputs: 1 cycle.
- Latency from a `ps2_key` event to outputs: 2 cycles.
- Sequencer: request high at cycle n (via `joy`) means `out_coin` and `busy` rise at n+1. `out_start[k]` falls at n+1+(COIN+GAP+START)×TICK_DIV, together with `busy`.
- If requests for several players rise in the same cycle, the lowest index wins and the others are lost.
- RESET mid-sequence: all outputs are 0 on the next cycle and the FSM is in IDLE.
- Tick counters are ⌈log2(max count+1)⌉ bits wide and saturate-free: they compare for equality and then reload.

## Configuration
- Macro: `INPUT_AUTOFIRE_EN`.
- Defined:
  - While `autofire_en[k]` and logical fire are both held, `out_fire[k]` starts high one cycle after fire rises. It then toggles every AUTOFIRE_TICKS×TICK_DIV cycles.
  - The per-player phase counter restarts on each fire rising edge.
  - Releasing fire drives the output low the next cycle.
- Undefined:
  - No autofire logic is generated and `autofire_en` is ignored.
  - `out_fire[k]` is always logical fire, delayed 1 cycle.

## Test plan
- Reset: hold RESET 3 cycles with all inputs active → every output is 0 during reset and on the first cycle after release, and no key event is registered.
- Rotation: `rotate`=1, joy0=0x0008 → `out_dir[3:0]`=4'b0001 one cycle later. With `rotate`=2 → 4'b0100; with `rotate`=3 → 4'b0010.
- Sequencer: TICK_DIV=4, COIN=3, GAP=2, START=3, PLAYERS=2. joy1 bit5 rises at cycle 10 → `out_coin` high cycles 11–22, low 23–30. `out_start[1]` high cycles 31–42. `busy` high cycles 11–42.
- Arbitration: joy0 and joy1 bit5 rise in the same cycle → only `out_start[0]` pulses. A new joy1 edge at `busy`=1 produces no second sequence. RESET asserted during COIN → `out_coin`=0 on the next cycle.
- Keyboard: `ps2_key`=0x203 then, after toggling bit 10, 0x603 → `out_skip` rises 2 cycles after the first event and clears 2 cycles after the release event (0x403/toggle). Code 0x175 drives up identically to 0x075.
- Autofire: TICK_DIV=4, AUTOFIRE_TICKS=2, `autofire_en[0]`=1, fire held 40 cycles → with the macro, `out_fire[0]` runs high 8 cycles, low 8 cycles, repeating. Without the macro it is steady high.
